mmx_wb_stage: RTL and testbench
===============================

// Module: mmx_wb_stage
// PURPOSE
//  Writeback end of the execute-to-register interface for the MMX/ECX datapath. Accepts
//  alu3-class results (64-bit MMX lane data or 32-bit decremented ECX) over a valid/ready
//  handshake and buffers them in a 2-entry skid queue. Drains them in order into the
//  8x64 MMX register file write port and the ECX write port. Sits between the execute
//  stage and the architectural register files. Exports a per-register pending mask and a
//  REP-termination pulse for the decode and sequencer logic.
// PARAMETERS
//  DATA_W   64  result width (MMX register width; ECX uses [31:0])
//  NREG     8   number of MMX registers; mm_waddr width = 3
//  DEPTH    2   skid queue entries; fixed at 2, other values unsupported
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  rst         in   1   synchronous, active-high reset
//  ex_valid    in   1   execute presents a result this cycle
//  ex_ready    out  1   queue can accept; transfer = ex_valid & ex_ready
//  ex_res      in   64  result (alu_res3); ECX results in [31:0]
//  ex_dest     in   3   destination MMX register index
//  ex_wr_mm    in   1   result targets MMX register file
//  ex_wr_ecx   in   1   result targets ECX (both may be set; both written)
//  wb_stall    in   1   register-file port busy; head entry held
//  mm_we       out  1   MMX regfile write enable (one cycle per entry)
//  mm_waddr    out  3   MMX regfile write index
//  mm_wdata    out  64  MMX regfile write data
//  ecx_we      out  1   ECX write enable
//  ecx_wdata   out  32  ECX write data
//  rep_done    out  1   one-cycle pulse: ECX written with value 0
//  pend_mask   out  8   bit r set while any queued entry writes MMX register r
//  fwd_valid   out  1   forwarding data valid (WB_FWD_EN only)
//  fwd_dest    out  3   forwarded register index
//  fwd_data    out  64  forwarded data: youngest queued MMX-writing entry
// BEHAVIOUR
//  - Reset: queue empty; count=0; ex_ready=1; mm_we=ecx_we=rep_done=0.
//    mm_waddr, mm_wdata, ecx_wdata, fwd_* and pend_mask all 0.
//  - Reset mid-operation discards all queued entries with no writes issued.
//  - States by count: EMPTY(0), ONE(1), FULL(2). ex_ready = (count != 2), from registered count.
//  - Push: an entry is accepted on ex_valid&ex_ready. It captures {res, dest, wr_mm, wr_ecx}.
//    An entry with wr_mm=wr_ecx=0 is accepted and dropped (it never occupies the queue).
//  - Pop: the head drains when count>0 and !wb_stall. Write outputs are registered:
//    mm_we/ecx_we assert the cycle after the pop decision.
//    Minimum latency is accept at edge N -> write strobe high in cycle N+1.
//  - mm_we=head.wr_mm and ecx_we=head.wr_ecx, each one cycle, strobed at pop.
//    Write data is held stable while the strobe is high.
//  - ecx_wdata=head.res[31:0]; bits [63:32] ignored for ECX.
//    rep_done pulses with ecx_we when ecx_wdata==0.
//  - Simultaneous push and pop: allowed in ONE, count stays 1, FIFO order kept.
//    In EMPTY a push is not bypassed; it is written next cycle at the earliest.
//    In FULL no push can occur.
//  - Order: strictly in order, and no entry is lost or duplicated.
//    If wb_stall is held, the queue holds indefinitely and ex_ready=0 once FULL.
//  - pend_mask is combinational from queued entries with wr_mm=1.
//    It clears in the same cycle the write strobe is issued.
// CONFIGURATION
//  WB_FWD_EN defined: fwd_valid=1 when any queued entry has wr_mm.
//    fwd_dest/fwd_data come from the youngest such entry; when both entries match, the tail wins.
//  WB_FWD_EN undefined: fwd_valid, fwd_dest and fwd_data are tied to 0, with no forwarding logic.
// TESTING
//  1 rst held 2 cycles mid-queue (count=2) -> no write strobes, count=0, ex_ready=1, pend_mask=0
//  2 push res=64'h0001_0002_0003_0004, dest=5, wr_mm, stall=0 -> next cycle mm_we=1,
//    mm_waddr=5, data matches; pend_mask=8'h20 for exactly one cycle before
//  3 wb_stall=1, push 3 entries back-to-back -> 2 accepted, ex_ready=0 on 3rd;
//    release stall -> writes in order, 3rd accepted after first pop
//  4 push wr_ecx res=32'h0000_0001 then 32'h0 -> ecx_we twice, rep_done only with 2nd write
//  5 count=1, simultaneous push+pop every cycle for 10 results -> 10 writes in order, ex_ready stays 1
//  6 WB_FWD_EN, stall=1, queue dest=2 then dest=2 new data -> fwd_dest=2, fwd_data=newer;
//    undefined -> fwd_*=0

Source files
------------

// File: rtl/mmx_wb_stage_if.sv
// Execute-to-writeback result handshake for mmx_wb_stage.
// Master is the execute stage; slave is the writeback queue.
interface mmx_wb_stage_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREG   = 8
);
  localparam int unsigned AW = $clog2(NREG);

  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_res;
  logic [AW-1:0]     ex_dest;
  logic              ex_wr_mm;
  logic              ex_wr_ecx;

  modport master (
    output ex_valid, ex_res, ex_dest, ex_wr_mm, ex_wr_ecx,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_res, ex_dest, ex_wr_mm, ex_wr_ecx,
    output ex_ready
  );
endinterface

// File: rtl/mmx_wb_stage.sv
// MMX/ECX writeback stage: 2-entry in-order skid queue draining into the MMX and ECX write ports.
// Optional forwarding of the youngest queued MMX result is enabled by defining WB_FWD_EN.
module mmx_wb_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREG   = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  mmx_wb_stage_if.slave           ex,
  input  logic                    wb_stall,
  output logic                    mm_we,
  output logic [$clog2(NREG)-1:0] mm_waddr,
  output logic [DATA_W-1:0]       mm_wdata,
  output logic                    ecx_we,
  output logic [31:0]             ecx_wdata,
  output logic                    rep_done,
  output logic [NREG-1:0]         pend_mask,
  output logic                    fwd_valid,
  output logic [$clog2(NREG)-1:0] fwd_dest,
  output logic [DATA_W-1:0]       fwd_data
);
  localparam int unsigned AW = $clog2(NREG);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic [AW-1:0]     dest;
    logic              wr_mm;
    logic              wr_ecx;
  } entry_t;

  state_e state_q, state_d;
  entry_t slot_q [2];
  entry_t slot_d [2];
  entry_t new_ent;
  entry_t head;
  logic   push, pop;

  logic              mm_we_q, ecx_we_q, rep_done_q;
  logic [AW-1:0]     mm_waddr_q;
  logic [DATA_W-1:0] mm_wdata_q;
  logic [31:0]       ecx_wdata_q;

  assign new_ent = '{res: ex.ex_res, dest: ex.ex_dest, wr_mm: ex.ex_wr_mm, wr_ecx: ex.ex_wr_ecx};
  assign head    = slot_q[0];

  // State register: the state encodes the queue occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (push) state_d = StOne;
      StOne: begin
        if (pop && !push)      state_d = StEmpty;
        else if (push && !pop) state_d = StFull;
      end
      StFull:  if (pop) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  // Accepted entries with no target are consumed without occupying a slot.
  always_comb begin
    ex.ex_ready = (state_q != state_e'(DEPTH));
    push        = ex.ex_valid && ex.ex_ready && (ex.ex_wr_mm || ex.ex_wr_ecx);
    pop         = (state_q != StEmpty) && !wb_stall;
  end

  // Slot 0 is always the head; slot 1 is valid only when full.
  always_comb begin
    slot_d[0] = slot_q[0];
    slot_d[1] = slot_q[1];
    if (pop) begin
      slot_d[0] = slot_q[1];
    end
    if (push) begin
      if (state_q == StEmpty || (state_q == StOne && pop)) begin
        slot_d[0] = new_ent;
      end else begin
        slot_d[1] = new_ent;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else begin
      slot_q[0] <= slot_d[0];
      slot_q[1] <= slot_d[1];
    end
  end

  // Write ports are registered; strobes last exactly one cycle per popped entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      mm_we_q     <= 1'b0;
      ecx_we_q    <= 1'b0;
      rep_done_q  <= 1'b0;
      mm_waddr_q  <= '0;
      mm_wdata_q  <= '0;
      ecx_wdata_q <= '0;
    end else begin
      mm_we_q    <= pop && head.wr_mm;
      ecx_we_q   <= pop && head.wr_ecx;
      rep_done_q <= pop && head.wr_ecx && (head.res[31:0] == 32'd0);
      if (pop && head.wr_mm) begin
        mm_waddr_q <= head.dest;
        mm_wdata_q <= head.res;
      end
      if (pop && head.wr_ecx) begin
        ecx_wdata_q <= head.res[31:0];
      end
    end
  end

  assign mm_we     = mm_we_q;
  assign mm_waddr  = mm_waddr_q;
  assign mm_wdata  = mm_wdata_q;
  assign ecx_we    = ecx_we_q;
  assign ecx_wdata = ecx_wdata_q;
  assign rep_done  = rep_done_q;

  always_comb begin
    pend_mask = '0;
    if (state_q != StEmpty && slot_q[0].wr_mm) pend_mask[slot_q[0].dest] = 1'b1;
    if (state_q == StFull && slot_q[1].wr_mm)  pend_mask[slot_q[1].dest] = 1'b1;
  end

`ifdef WB_FWD_EN
  // Youngest MMX-writing entry wins, so the tail is preferred over the head.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_dest  = '0;
    fwd_data  = '0;
    if (state_q == StFull && slot_q[1].wr_mm) begin
      fwd_valid = 1'b1;
      fwd_dest  = slot_q[1].dest;
      fwd_data  = slot_q[1].res;
    end else if (state_q != StEmpty && slot_q[0].wr_mm) begin
      fwd_valid = 1'b1;
      fwd_dest  = slot_q[0].dest;
      fwd_data  = slot_q[0].res;
    end
  end
`else
  assign fwd_valid = 1'b0;
  assign fwd_dest  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mmx_wb_stage.sv
// Scoreboard bench for mmx_wb_stage: stimulus queues expected writes, a monitor checks each strobe.
module tb_mmx_wb_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_stall;
  logic        mm_we, ecx_we, rep_done, fwd_valid;
  logic [2:0]  mm_waddr, fwd_dest;
  logic [63:0] mm_wdata, fwd_data;
  logic [31:0] ecx_wdata;
  logic [7:0]  pend_mask;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  addr;
    logic        mm;
    logic        ecx;
    logic        rep;
  } exp_t;
  exp_t exp_q[$];

  mmx_wb_stage_if #(.DATA_W(64), .NREG(8)) ex_if ();

  mmx_wb_stage #(.DATA_W(64), .NREG(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex        (ex_if),
    .wb_stall  (wb_stall),
    .mm_we     (mm_we),
    .mm_waddr  (mm_waddr),
    .mm_wdata  (mm_wdata),
    .ecx_we    (ecx_we),
    .ecx_wdata (ecx_wdata),
    .rep_done  (rep_done),
    .pend_mask (pend_mask),
    .fwd_valid (fwd_valid),
    .fwd_dest  (fwd_dest),
    .fwd_data  (fwd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mm_we || ecx_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {62'd0, mm_we, ecx_we}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_mm_we", {63'd0, mm_we}, {63'd0, e.mm});
        check("wr_ecx_we", {63'd0, ecx_we}, {63'd0, e.ecx});
        if (e.mm) begin
          check("wr_mm_waddr", {61'd0, mm_waddr}, {61'd0, e.addr});
          check("wr_mm_wdata", mm_wdata, e.data);
        end
        if (e.ecx) begin
          check("wr_ecx_wdata", {32'd0, ecx_wdata}, {32'd0, e.data[31:0]});
          check("wr_rep_done", {63'd0, rep_done}, {63'd0, e.rep});
        end
      end
    end else if (rep_done) begin
      check("rep_done_without_ecx_we", {63'd0, rep_done}, 64'd0);
    end
  end

  task automatic idle();
    ex_if.ex_valid = 1'b0;
  endtask

  // Presents one result and returns once it is accepted (called at posedge+1).
  task automatic send(input logic [63:0] res, input logic [2:0] dest, input logic mm,
                      input logic ecx, input logic rep, input bit record, output int waits);
    ex_if.ex_valid  = 1'b1;
    ex_if.ex_res    = res;
    ex_if.ex_dest   = dest;
    ex_if.ex_wr_mm  = mm;
    ex_if.ex_wr_ecx = ecx;
    waits = 0;
    forever begin
      @(negedge clk);
      if (ex_if.ex_ready) break;
      waits++;
      if (waits > 100) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: ex_ready stuck 0, expected 1 within 100 cycles");
        break;
      end
    end
    @(posedge clk);
    if (record && (mm || ecx)) exp_q.push_back('{data: res, addr: dest, mm: mm, ecx: ecx, rep: rep});
    #1;
  endtask

  task automatic drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    check("drain_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int w;
    rst = 1'b1;
    wb_stall = 1'b0;
    ex_if.ex_valid = 1'b0;
    ex_if.ex_res = '0;
    ex_if.ex_dest = '0;
    ex_if.ex_wr_mm = 1'b0;
    ex_if.ex_wr_ecx = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ex_ready", {63'd0, ex_if.ex_ready}, 64'd1);
    check("rst_strobes", {61'd0, mm_we, ecx_we, rep_done}, 64'd0);
    check("rst_pend_mask", {56'd0, pend_mask}, 64'd0);
    check("rst_mm_port", {mm_waddr, mm_wdata[60:0]} | {61'd0, mm_wdata[63:61]}, 64'd0);
    check("rst_ecx_wdata", {32'd0, ecx_wdata}, 64'd0);
    check("rst_fwd", {60'd0, fwd_valid, fwd_dest} | fwd_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset with a full queue: entries are discarded with no writes.
    wb_stall = 1'b1;
    send(64'h1111_1111_1111_1111, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, w);
    send(64'h2222_2222_2222_2222, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, w);
    idle();
    @(negedge clk);
    check("t1_full_ready", {63'd0, ex_if.ex_ready}, 64'd0);
    check("t1_full_pend", {56'd0, pend_mask}, 64'h06);
    @(posedge clk); #1;
    rst = 1'b1;
    wb_stall = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    check("t1_ready", {63'd0, ex_if.ex_ready}, 64'd1);
    check("t1_pend", {56'd0, pend_mask}, 64'd0);
    repeat (3) @(negedge clk);
    check("t1_no_strobe", {62'd0, mm_we, ecx_we}, 64'd0);

    // Single MMX write: pend_mask for one cycle, then the strobe.
    @(posedge clk); #1;
    send(64'h0001_0002_0003_0004, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, w);
    idle();
    @(negedge clk);
    check("t2_pend_before", {56'd0, pend_mask}, 64'h20);
    check("t2_we_before", {63'd0, mm_we}, 64'd0);
    @(negedge clk);
    check("t2_we", {63'd0, mm_we}, 64'd1);
    check("t2_pend_after", {56'd0, pend_mask}, 64'd0);
    drain();

    // Stall fills the queue; the third result waits for the first pop.
    @(posedge clk); #1;
    wb_stall = 1'b1;
    send(64'hC0C0_0000_0000_0001, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, w);
    send(64'hC0C0_0000_0000_0002, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, w);
    ex_if.ex_res = 64'hC0C0_0000_0000_0003;
    ex_if.ex_dest = 3'd0;
    repeat (3) @(negedge clk);
    check("t3_third_blocked", {63'd0, ex_if.ex_ready}, 64'd0);
    check("t3_pend", {56'd0, pend_mask}, 64'h18);
    @(posedge clk); #1;
    wb_stall = 1'b0;
    send(64'hC0C0_0000_0000_0003, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, w);
    check("t3_third_wait", 64'(w), 64'd1);
    idle();
    drain();

    // ECX writes: rep_done only when the low word is zero.
    @(posedge clk); #1;
    send(64'h0000_0000_0000_0001, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, w);
    send(64'hFFFF_FFFF_0000_0000, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, w);
    send(64'h0000_0000_0000_0000, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1, w);
    idle();
    drain();

    // Result with no target is accepted and dropped.
    @(posedge clk); #1;
    send(64'hDEAD_BEEF_DEAD_BEEF, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, w);
    idle();
    @(negedge clk);
    check("drop_pend", {56'd0, pend_mask}, 64'd0);
    check("drop_ready", {63'd0, ex_if.ex_ready}, 64'd1);
    drain();

    // Streaming push+pop every cycle keeps count at 1 and ex_ready high.
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      send(64'h5A5A_0000_0000_0000 + 64'(i), 3'(i), 1'b1, 1'b0, 1'b0, 1'b1, w);
      check("t5_ready_each_cycle", 64'(w), 64'd0);
    end
    idle();
    drain();

    // Two queued writes to the same register: forward the newer one.
    @(posedge clk); #1;
    wb_stall = 1'b1;
    send(64'hAAAA_AAAA_AAAA_AAAA, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, w);
    send(64'hBBBB_BBBB_BBBB_BBBB, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, w);
    idle();
    @(negedge clk);
    check("t6_pend", {56'd0, pend_mask}, 64'h04);
`ifdef WB_FWD_EN
    check("t6_fwd_valid", {63'd0, fwd_valid}, 64'd1);
    check("t6_fwd_dest", {61'd0, fwd_dest}, 64'd2);
    check("t6_fwd_data", fwd_data, 64'hBBBB_BBBB_BBBB_BBBB);
`else
    check("t6_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    check("t6_fwd_dest", {61'd0, fwd_dest}, 64'd0);
    check("t6_fwd_data", fwd_data, 64'd0);
`endif
    @(posedge clk); #1;
    wb_stall = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
